// File: rtl/bip_control_unit_if.sv
// Program-counter / program-memory / datapath control bundle of the BIP core.
// The control unit is the master: it consumes Addr and instr, and drives the
// next PC value plus all datapath strobes. The PC and datapath are the slave.
interface bip_control_unit_if #(
    parameter int AB  = 11,
    parameter int OPW = 5
);
    logic [AB-1:0]     Addr;         // current PC value
    logic [OPW+AB-1:0] instr;        // program-memory word, valid in EXEC
    logic [AB-1:0]     address_bus;  // next PC value
    logic              WrPC;         // PC load enable
    logic [1:0]        SelA;         // accumulator source
    logic              SelB;         // ALU B source
    logic              WrAcc;        // accumulator write enable
    logic              Op;           // ALU add (0) / subtract (1)
    logic              WrRam;        // data RAM write strobe
    logic              RdRam;        // data RAM read strobe

    modport master (
        input  Addr, instr,
        output address_bus, WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam
    );

    modport slave (
        output Addr, instr,
        input  address_bus, WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam
    );
endinterface

// File: rtl/bip_control_unit.sv
// BIP instruction sequencer and decoder.
// IDLE -> FETCH -> EXEC -> FETCH ... until HLT, then HALT until reset.
// FETCH presents Addr to program memory; EXEC decodes the returned word
// combinationally and loads Addr+1 into the PC for every non-HLT opcode.
// Reset forces a PC reload of 0 on the same edge and suppresses all strobes.
module bip_control_unit #(
    parameter int AB  = 11,
    parameter int OPW = 5,
    parameter int CW  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    bip_control_unit_if.master     bus,
    output logic                   halted,
    output logic [CW-1:0]          cycle_count,
    output logic [CW-1:0]          instr_count,
    output logic [1:0]             o_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
    localparam logic [OPW-1:0] OP_STO  = OPW'(1);
    localparam logic [OPW-1:0] OP_LD   = OPW'(2);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(4);
    localparam logic [OPW-1:0] OP_ADDI = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(6);
    localparam logic [OPW-1:0] OP_SUBI = OPW'(7);

    state_t          r_state;
    logic [CW-1:0]   r_cycle_count;
    logic [CW-1:0]   r_instr_count;
    logic [OPW-1:0]  w_opcode;
    logic            w_retire;

    assign w_opcode = bus.instr[OPW+AB-1:AB];
    // An instruction retires on the EXEC cycle of any opcode other than HLT.
    assign w_retire = (r_state == S_EXEC) && (w_opcode != OP_HLT);

    // Mealy decode: controls only during EXEC, reset overrides with a PC reload of 0.
    always_comb begin
        bus.address_bus = bus.Addr;
        bus.WrPC        = 1'b0;
        bus.SelA        = 2'b00;
        bus.SelB        = 1'b0;
        bus.WrAcc       = 1'b0;
        bus.Op          = 1'b0;
        bus.WrRam       = 1'b0;
        bus.RdRam       = 1'b0;
        if (reset) begin
            bus.address_bus = '0;
            bus.WrPC        = 1'b1;
        end else if (w_retire) begin
            bus.address_bus = bus.Addr + AB'(1);
            bus.WrPC        = 1'b1;
            case (w_opcode)
                OP_STO:  bus.WrRam = 1'b1;
                OP_LD:   begin bus.WrAcc = 1'b1; bus.RdRam = 1'b1; end
                OP_LDI:  begin bus.SelA = 2'b01; bus.WrAcc = 1'b1; end
                OP_ADD:  begin bus.SelA = 2'b10; bus.WrAcc = 1'b1; bus.RdRam = 1'b1; end
                OP_ADDI: begin bus.SelA = 2'b10; bus.SelB = 1'b1; bus.WrAcc = 1'b1; end
                OP_SUB:  begin bus.SelA = 2'b10; bus.WrAcc = 1'b1; bus.Op = 1'b1; bus.RdRam = 1'b1; end
                OP_SUBI: begin bus.SelA = 2'b10; bus.SelB = 1'b1; bus.WrAcc = 1'b1; bus.Op = 1'b1; end
                default: ;  // unassigned opcodes execute as NOP
            endcase
        end
    end

    // Sequencer state and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            if ((r_state == S_FETCH || r_state == S_EXEC) && r_cycle_count != '1) begin
                r_cycle_count <= r_cycle_count + CW'(1);
            end
            if (w_retire && r_instr_count != '1) begin
                r_instr_count <= r_instr_count + CW'(1);
            end
            case (r_state)
                S_IDLE:  if (start) r_state <= S_FETCH;
                S_FETCH: r_state <= S_EXEC;
                S_EXEC:  r_state <= (w_opcode == OP_HLT) ? S_HALT : S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign halted      = (r_state == S_HALT) && !reset;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;
    assign o_state     = r_state;

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: two instances (CW=16 and CW=4) share one
// program memory and PC model; a phase-level model checks every cycle.
module tb_bip_control_unit;

    localparam int AB  = 11;
    localparam int OPW = 5;
    localparam int W   = OPW + AB;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_EXEC  = 2;
    localparam int P_HALT  = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AB-1:0] pc;
    logic [W-1:0]  instr_q;
    logic [W-1:0]  mem [2048];
    logic          pc_load;
    logic [AB-1:0] pc_load_val;

    logic          halted16, halted4;
    logic [15:0]   cyc16, ins16;
    logic [3:0]    cyc4, ins4;
    logic [1:0]    st16, st4;

    int n_checks = 0;
    int n_errors = 0;

    bip_control_unit_if #(.AB(AB), .OPW(OPW)) bus16 ();
    bip_control_unit_if #(.AB(AB), .OPW(OPW)) bus4 ();

    bip_control_unit #(.AB(AB), .OPW(OPW), .CW(16)) u_dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus16.master),
        .halted(halted16), .cycle_count(cyc16), .instr_count(ins16), .o_state(st16)
    );

    bip_control_unit #(.AB(AB), .OPW(OPW), .CW(4)) u_sat (
        .clk(clk), .reset(reset), .start(start), .bus(bus4.master),
        .halted(halted4), .cycle_count(cyc4), .instr_count(ins4), .o_state(st4)
    );

    assign bus16.Addr  = pc;
    assign bus16.instr = instr_q;
    assign bus4.Addr   = pc;
    assign bus4.instr  = instr_q;

    // ---------------- clock / environment ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program_Counter and one-cycle-latency program memory.
    always @(posedge clk) begin
        if (pc_load)          pc <= pc_load_val;
        else if (bus16.WrPC)  pc <= bus16.address_bus;
        instr_q <= mem[pc];
    end

    // ---------------- check helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Decode table: {SelA, SelB, WrAcc, Op, WrRam, RdRam}
    function automatic logic [6:0] spec_decode(input logic [4:0] opc);
        case (opc)
            5'd1:    return 7'b00_0_0_0_1_0;  // STO
            5'd2:    return 7'b00_0_1_0_0_1;  // LD
            5'd3:    return 7'b01_0_1_0_0_0;  // LDI
            5'd4:    return 7'b10_0_1_0_0_1;  // ADD
            5'd5:    return 7'b10_1_1_0_0_0;  // ADDI
            5'd6:    return 7'b10_0_1_1_0_1;  // SUB
            5'd7:    return 7'b10_1_1_1_0_0;  // SUBI
            default: return 7'b00_0_0_0_0_0;  // HLT and NOPs
        endcase
    endfunction

    function automatic int clamp(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    int            m_phase = P_IDLE;
    int            m_cyc   = 0;
    int            m_ins   = 0;
    bit            m_valid = 0;
    logic [AB-1:0] e_ab;
    logic          e_wrpc, e_halt, ab_care;
    logic [6:0]    e_dec;
    logic [4:0]    opc;

    always @(negedge clk) begin
        opc     = instr_q[W-1:AB];
        e_ab    = pc;
        e_wrpc  = 1'b0;
        e_dec   = '0;
        e_halt  = 1'b0;
        ab_care = 1'b1;
        if (reset) begin
            e_ab   = '0;
            e_wrpc = 1'b1;
        end else begin
            e_halt = (m_phase == P_HALT);
            if (m_phase == P_EXEC) begin
                if (opc == 5'd0) begin
                    ab_care = 1'b0;
                end else begin
                    e_wrpc = 1'b1;
                    e_ab   = pc + 11'd1;
                    e_dec  = spec_decode(opc);
                end
            end
        end

        if (m_valid) begin
            chk("ctrl16", {(ab_care ? bus16.address_bus : 11'd0), bus16.WrPC, bus16.SelA, bus16.SelB,
                           bus16.WrAcc, bus16.Op, bus16.WrRam, bus16.RdRam, halted16},
                          {(ab_care ? e_ab : 11'd0), e_wrpc, e_dec, e_halt});
            chk("ctrl4",  {(ab_care ? bus4.address_bus : 11'd0), bus4.WrPC, bus4.SelA, bus4.SelB,
                           bus4.WrAcc, bus4.Op, bus4.WrRam, bus4.RdRam, halted4},
                          {(ab_care ? e_ab : 11'd0), e_wrpc, e_dec, e_halt});
            chk("cycle16", 32'(cyc16), 32'(clamp(m_cyc, 65535)));
            chk("instr16", 32'(ins16), 32'(clamp(m_ins, 65535)));
            chk("cycle4",  32'(cyc4),  32'(clamp(m_cyc, 15)));
            chk("instr4",  32'(ins4),  32'(clamp(m_ins, 15)));
        end

        // advance the model to the state after the coming rising edge
        if (reset) begin
            m_phase = P_IDLE;
            m_cyc   = 0;
            m_ins   = 0;
            m_valid = 1;
        end else begin
            if (m_phase == P_FETCH || m_phase == P_EXEC) m_cyc++;
            case (m_phase)
                P_IDLE:  if (start) m_phase = P_FETCH;
                P_FETCH: m_phase = P_EXEC;
                P_EXEC:  begin
                    if (opc == 5'd0) m_phase = P_HALT;
                    else begin m_phase = P_FETCH; m_ins++; end
                end
                default: m_phase = P_HALT;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        pc          = '0;
        instr_q     = '0;
        clear_mem();

        // Test 1: LDI 5 ; HLT
        mem[0] = {5'd3, 11'd5};
        mem[1] = {5'd0, 11'd0};
        do_reset();
        at_neg();
        chk("t1_idle_cycle", 32'(cyc16), 32'd0);
        pulse_start();                       // FETCH 0
        tick();                              // EXEC LDI
        at_neg();
        chk("t1_ldi_sela",  32'(bus16.SelA), 32'd1);
        chk("t1_ldi_wracc", 32'(bus16.WrAcc), 32'd1);
        chk("t1_ldi_wrpc",  32'(bus16.WrPC), 32'd1);
        chk("t1_ldi_ab",    32'(bus16.address_bus), 32'd1);
        tick();                              // FETCH 1
        tick();                              // EXEC HLT
        at_neg();
        chk("t1_hlt_wrpc",  32'(bus16.WrPC), 32'd0);
        tick();                              // HALT
        at_neg();
        chk("t1_halted",    32'(halted16), 32'd1);
        chk("t1_cycles",    32'(cyc16), 32'd4);
        chk("t1_instrs",    32'(ins16), 32'd1);

        // Test 2: ADD 3 ; SUBI 2 ; STO 7 ; HLT, start held high throughout
        clear_mem();
        mem[0] = {5'd4, 11'd3};
        mem[1] = {5'd7, 11'd2};
        mem[2] = {5'd1, 11'd7};
        mem[3] = {5'd0, 11'd0};
        do_reset();
        start = 1'b1;
        tick();                              // FETCH 0
        tick();                              // EXEC ADD
        at_neg();
        chk("t2_add_sela",  32'(bus16.SelA), 32'd2);
        chk("t2_add_selb",  32'(bus16.SelB), 32'd0);
        chk("t2_add_op",    32'(bus16.Op), 32'd0);
        chk("t2_add_rdram", 32'(bus16.RdRam), 32'd1);
        chk("t2_add_ab",    32'(bus16.address_bus), 32'd1);
        tick();
        tick();                              // EXEC SUBI
        at_neg();
        chk("t2_subi_selb",  32'(bus16.SelB), 32'd1);
        chk("t2_subi_op",    32'(bus16.Op), 32'd1);
        chk("t2_subi_rdram", 32'(bus16.RdRam), 32'd0);
        chk("t2_subi_ab",    32'(bus16.address_bus), 32'd2);
        tick();
        tick();                              // EXEC STO
        at_neg();
        chk("t2_sto_wrram", 32'(bus16.WrRam), 32'd1);
        chk("t2_sto_wracc", 32'(bus16.WrAcc), 32'd0);
        chk("t2_sto_ab",    32'(bus16.address_bus), 32'd3);
        tick();
        tick();                              // EXEC HLT
        tick();                              // HALT
        tick();
        tick();
        start = 1'b0;
        at_neg();
        chk("t2_halted", 32'(halted16), 32'd1);
        chk("t2_cycles", 32'(cyc16), 32'd8);
        chk("t2_instrs", 32'(ins16), 32'd3);

        // Test 3: NOP at the top address wraps the PC to 0
        clear_mem();
        mem[2047] = {5'd31, 11'd0};
        mem[0]    = {5'd0, 11'd0};
        do_reset();
        pc_load     = 1'b1;
        pc_load_val = 11'd2047;
        start       = 1'b1;
        tick();                              // FETCH 2047
        pc_load = 1'b0;
        start   = 1'b0;
        tick();                              // EXEC NOP
        at_neg();
        chk("t3_nop_ab",   32'(bus16.address_bus), 32'd0);
        chk("t3_nop_wrpc", 32'(bus16.WrPC), 32'd1);
        chk("t3_nop_ctrl", 32'({bus16.SelA, bus16.SelB, bus16.WrAcc, bus16.Op, bus16.WrRam, bus16.RdRam}), 32'd0);
        tick();                              // FETCH 0
        tick();                              // EXEC HLT
        tick();                              // HALT
        at_neg();
        chk("t3_instrs", 32'(ins16), 32'd1);

        // Test 4: reset during EXEC of STO
        clear_mem();
        mem[0] = {5'd1, 11'd7};
        mem[1] = {5'd0, 11'd0};
        do_reset();
        pulse_start();                       // FETCH 0
        tick();                              // EXEC STO
        reset = 1'b1;
        at_neg();
        chk("t4_rst_wrram", 32'(bus16.WrRam), 32'd0);
        chk("t4_rst_wrpc",  32'(bus16.WrPC), 32'd1);
        chk("t4_rst_ab",    32'(bus16.address_bus), 32'd0);
        tick();
        reset = 1'b0;
        at_neg();
        chk("t4_cycles", 32'(cyc16), 32'd0);
        chk("t4_instrs", 32'(ins16), 32'd0);
        tick();
        tick();
        at_neg();
        chk("t4_no_fetch", 32'(cyc16), 32'd0);

        // Test 5: 20 NOPs then HLT; the CW=4 instance saturates
        clear_mem();
        for (int i = 0; i < 20; i++) mem[i] = {5'(8 + i % 24), 11'(i)};
        mem[20] = {5'd0, 11'd0};
        do_reset();
        pulse_start();                       // FETCH 0
        for (int i = 0; i < 42; i++) tick(); // through EXEC HLT into HALT
        at_neg();
        chk("t5_halted",  32'(halted4), 32'd1);
        chk("t5_cycle4",  32'(cyc4), 32'd15);
        chk("t5_instr4",  32'(ins4), 32'd15);
        chk("t5_cycle16", 32'(cyc16), 32'd42);
        chk("t5_instr16", 32'(ins16), 32'd20);

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
- Instruction sequencer and decoder for the BIP core; sits directly upstream of Program_Counter.
- Drives address_bus and WrPC into the PC, and consumes the PC's current address (Addr) and the program-memory word.
- Runs a fetch/execute FSM, decodes opcodes into datapath controls, computes PC+1, and halts on HLT.
- Provides cycle and instruction counters for performance measurement.

Parameters:
- AB, 11, address width; must match Program_Counter AB.
- OPW, 5, opcode width.
- CW, 16, width of cycle_count and instr_count.

Ports:
- clk  input  1  system clock; rising-edge active.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; leaves IDLE.
- Addr  input  AB  current PC value from Program_Counter.
- instr  input  OPW+AB  program-memory word; opcode = [OPW+AB-1:AB], operand = [AB-1:0]; valid the cycle after Addr is presented.
- address_bus  output  AB  next PC value to Program_Counter.
- WrPC  output  1  PC load enable.
- SelA  output  2  accumulator source: 00 data RAM, 01 immediate operand, 10 ALU result.
- SelB  output  1  ALU B source: 0 data RAM, 1 immediate operand.
- WrAcc  output  1  accumulator write enable.
- Op  output  1  ALU operation: 0 add, 1 subtract.
- WrRam  output  1  data RAM write strobe.
- RdRam  output  1  data RAM read strobe.
- halted  output  1  high while in HALT.
- cycle_count  output  CW  clocks spent in FETCH and EXEC since leaving IDLE.
- instr_count  output  CW  instructions retired, HLT excluded.

Behaviour:
- Reset:
  - Synchronous, active-high; wins over every other input.
  - While reset is high: WrPC=1 and address_bus=0, so the PC reloads 0 on the same edge. All other control outputs are 0, halted=0.
  - On the reset edge: state becomes IDLE and both counters become 0.
  - Reset asserted in any state, including mid-EXEC, aborts the operation. No RAM write is issued in a reset cycle.
- States:
  - IDLE: all controls 0, WrPC=0. Goes to FETCH on the cycle after start=1; start is ignored in every other state.
  - FETCH: Addr drives program memory; all controls 0, WrPC=0. Always goes to EXEC on the next cycle (one-cycle memory latency).
  - EXEC: instr is valid and decoded combinationally (Mealy outputs).
    - Non-HLT opcode: WrPC=1, address_bus=Addr+1 modulo 2^AB (Addr = 2^AB-1 gives 0), next state FETCH, instr_count increments.
    - HLT: WrPC=0, all controls 0, next state HALT.
  - HALT: all controls 0, WrPC=0, halted=1. Stays in HALT until reset; start has no effect.
- Decode in EXEC (opcode: SelA SelB WrAcc Op WrRam RdRam):
  - 00000 HLT: 00 0 0 0 0 0.
  - 00001 STO: 00 0 0 0 1 0.
  - 00010 LD: 00 0 1 0 0 1.
  - 00011 LDI: 01 0 1 0 0 0.
  - 00100 ADD: 10 0 1 0 0 1.
  - 00101 ADDI: 10 1 1 0 0 0.
  - 00110 SUB: 10 0 1 1 0 1.
  - 00111 SUBI: 10 1 1 1 0 0.
  - Any other opcode: NOP, all controls 0, WrPC=1, PC advances, counted in instr_count.
- Timing:
  - Throughput is one instruction per 2 clocks; PC is updated at the end of EXEC.
  - Outside EXEC (and outside reset), address_bus = Addr.
- Counters:
  - cycle_count increments on every clock where state is FETCH or EXEC.
  - Both counters saturate at 2^CW-1; no wrap.
  - Both hold their values in HALT and IDLE.

Test Plan:
- Reset then start: memory[0]=LDI 5, memory[1]=HLT.
  - EXEC0: SelA=01, WrAcc=1, WrPC=1, address_bus=1.
  - EXEC1: WrPC=0; next cycle halted=1.
  - Final: cycle_count=4, instr_count=1.
- Program ADD 3, SUBI 2, STO 7, HLT. Check in each EXEC:
  - ADD: SelA=10, SelB=0, Op=0, RdRam=1.
  - SUBI: SelB=1, Op=1, RdRam=0.
  - STO: WrRam=1, WrAcc=0.
  - address_bus increments 1, 2, 3.
- Addr=2047 (AB=11) in EXEC with a NOP opcode 11111 -> address_bus=0, WrPC=1, all controls 0, instr_count+1.
- Reset asserted during EXEC of STO:
  - That cycle: WrRam=0, WrPC=1, address_bus=0.
  - Next cycle: state IDLE, counters 0, no FETCH until start.
- start pulses while in FETCH, EXEC and HALT -> no state change or extra fetch; halted stays 1 in HALT.
- CW=4, 20-instruction NOP loop ending in HLT -> cycle_count and instr_count saturate at 15.
